// File: rtl/bin_to_bcd_iter_if.sv
// Handshake bundle for bin_to_bcd_iter: a val/rdy operand channel into the
// converter and a val/rdy result channel out of it.
// master: producer/consumer side; slave: the converter.
interface bin_to_bcd_iter_if #(
    parameter int p_nbits   = 8,
    parameter int p_ndigits = 3
);
    logic                     in_val;
    logic                     in_rdy;
    logic [p_nbits-1:0]       in;
    logic                     out_val;
    logic                     out_rdy;
    logic [4*p_ndigits-1:0]   out_bcd;

    modport master (
        output in_val, in, out_rdy,
        input  in_rdy, out_val, out_bcd
    );

    modport slave (
        input  in_val, in, out_rdy,
        output in_rdy, out_val, out_bcd
    );
endinterface

// File: rtl/bin_to_bcd_iter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Operand and result move over val/rdy handshakes in bin_to_bcd_iter_if.
// Optional feature macro: BIN_TO_BCD_ITER_OVERLAP_EN -- lets a new operand be
// accepted in the same cycle the finished result is taken, so back-to-back
// conversions run every p_nbits+1 cycles instead of p_nbits+2.
module bin_to_bcd_iter #(
    parameter int p_nbits   = 8,
    parameter int p_ndigits = 3
) (
    input logic                 clk,
    input logic                 rst,
    bin_to_bcd_iter_if.slave    bus
);

    // Number of decimal digits needed for the largest operand 2^p_nbits - 1.
    function automatic int f_ndig_used();
        logic [p_nbits+3:0] v;
        int                 d;
        v = {4'b0000, {p_nbits{1'b1}}};
        d = 1;
        while (v >= (p_nbits+4)'(10)) begin
            v = v / (p_nbits+4)'(10);
            d++;
        end
        return d;
    endfunction

    // Bits needed for the most significant used digit (its largest value is
    // the leading decimal digit of 2^p_nbits - 1).
    function automatic int f_top_bits();
        logic [p_nbits+3:0] v;
        int                 b;
        v = {4'b0000, {p_nbits{1'b1}}};
        while (v >= (p_nbits+4)'(10))
            v = v / (p_nbits+4)'(10);
        b = 0;
        while (v != '0) begin
            v = v >> 1;
            b++;
        end
        return b;
    endfunction

    localparam int c_ndig_used  = f_ndig_used();
    localparam int c_top_bits   = f_top_bits();
    // Only the bits that can ever be non-zero are stored; everything above is
    // tied to 0 so those output bits stay 0 even for an X operand.
    localparam int c_live_bits  = 4*(c_ndig_used-1) + c_top_bits;
    localparam int c_cnt_w      = $clog2(p_nbits+1);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(p_nbits-1);

    if (p_nbits < 1 || p_ndigits < c_ndig_used) begin : g_bad_params
        $error("bin_to_bcd_iter: p_ndigits=%0d too small for p_nbits=%0d",
               p_ndigits, p_nbits);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [c_live_bits-1:0] r_bcd;
    logic [p_nbits-1:0]     r_shift;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_live_bits-1:0] w_adj;

    // Add-3 correction of every full digit that is 5 or more. The top used
    // digit is passed through: it is provably below 5 before every shift,
    // otherwise the result would not fit in c_ndig_used digits.
    always_comb begin
        // NOTE: default assignment first so every path writes w_adj and no latch is inferred.
        w_adj = r_bcd;
        for (int i = 0; i < c_ndig_used-1; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Control FSM and datapath registers; synchronous reset abandons any conversion.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_val) begin
                        r_shift <= bus.in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + 1'b1;
                    if (r_cnt == c_last_step)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_rdy) begin
`ifdef BIN_TO_BCD_ITER_OVERLAP_EN
                        if (bus.in_val) begin
                            r_shift <= bus.in;
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BIN_TO_BCD_ITER_OVERLAP_EN
    assign bus.in_rdy  = ((r_state == S_IDLE) || (r_state == S_DONE && bus.out_rdy)) && !rst;
`else
    assign bus.in_rdy  = (r_state == S_IDLE) && !rst;
`endif
    assign bus.out_val = (r_state == S_DONE);

    if (c_live_bits < 4*p_ndigits) begin : g_pad
        assign bus.out_bcd = {{(4*p_ndigits-c_live_bits){1'b0}}, r_bcd};
    end else begin : g_nopad
        assign bus.out_bcd = r_bcd;
    end

endmodule

// File: doc/bin_to_bcd_iter.md
# bin_to_bcd_iter

Parametrised, iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per cycle. Generalises the fixed 5-bit combinational binary-to-BCD block to any input width and digit count. Data moves through latency-insensitive val/rdy handshakes on both sides. Sits between the datapath and the seven-segment display drivers.

## Interface
- p_nbits, 8, binary input width; must be ≥ 1.
- p_ndigits, 3, number of BCD output digits; must satisfy 10^p_ndigits ≥ 2^p_nbits. Violation is an elaboration-time `$error`.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  1  producer has a valid operand on `in`.
- in_rdy  output  1  converter can accept an operand.
- in  input  p_nbits  unsigned binary operand.
- out_val  output  1  `out_bcd` holds a completed result.
- out_rdy  input  1  consumer can accept the result.
- out_bcd  output  4*p_ndigits  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is the ones digit.

## Operation
- FSM states:
  - IDLE (reset state)
  - CALC
  - DONE
- Input transfer: `in_val && in_rdy` at a rising edge.
- Output transfer: `out_val && out_rdy` at a rising edge.
- `in_rdy = (state == IDLE) && !rst`.
- `out_val = (state == DONE)`.
- IDLE: on an input transfer, load the shift register with `in`, clear the BCD register and the step counter, then go to CALC. `in` is sampled only on a transfer, so X on `in` while `in_val` = 0 must not disturb any state.
- CALC, one step per cycle:
  - Every BCD digit ≥ 5 gets +3 (4-bit add, no carry out).
  - Then the concatenation {bcd, shift} is shifted left by 1, so the MSB of the shift register enters bit 0 of digit 0.
  - The step counter increments; its width is $clog2(p_nbits+1).
  - After step p_nbits, go to DONE.
- DONE:
  - `out_bcd` is held stable until the output transfer.
  - On the output transfer, go to IDLE.
  - `in_val` is ignored.
- Digits never exceed 9. Digit nibbles above the highest digit needed for 2^p_nbits − 1 are constant 0, including when the input is X.
- `out_bcd` outside DONE is the internal register value and is not meaningful.
- Reset, in any state and including mid-CALC: abandon the conversion, go to IDLE, clear the BCD, shift and counter registers. No output transfer occurs for the abandoned operand.

## Timing
- Reset values: in_rdy = 0 (while rst is high), out_val = 0, out_bcd = 0. in_rdy = 1 in the first cycle after rst deasserts.
- Let cycle 0 be the cycle of the input transfer.
  - Cycles 1..p_nbits: CALC, with in_rdy = 0 and out_val = 0.
  - Cycle p_nbits+1: out_val = 1. Latency is p_nbits+1 cycles.
- With out_rdy held high: output transfer in cycle p_nbits+1, IDLE in cycle p_nbits+2. Initiation interval is p_nbits+2 cycles.
- Backpressure: out_val and out_bcd hold for as long as out_rdy = 0. The result is never dropped or overwritten.
- out_rdy asserted before out_val has no effect.

## Configuration
- Macro: `BIN_TO_BCD_ITER_OVERLAP_EN`.
- Defined:
  - `in_rdy = ((state == IDLE) || (state == DONE && out_rdy)) && !rst`.
  - A simultaneous output and input transfer in DONE goes directly to CALC and reloads the registers with the new operand.
  - Back-to-back initiation interval becomes p_nbits+1 cycles.
  - in_rdy is combinationally dependent on out_rdy.
- Undefined:
  - in_rdy is high only in IDLE, as described in Operation.
  - Initiation interval is p_nbits+2 cycles.
  - No combinational path from out_rdy to in_rdy.

## Test plan
- Default parameters (8/3): in = 255 in cycle 0 → out_val first high in cycle 9 with out_bcd = 12'h255; in = 0 → 12'h000; in = 100 → 12'h100.
- p_nbits = 5, p_ndigits = 2, all inputs 0..31 → out_bcd = {tens, ones} decimal (e.g. 19 → 8'h19, 31 → 8'h31); bits [7:6] = 0 on every result and for an X input.
- Backpressure (8/3): in = 137, out_rdy low for 5 cycles after out_val rises → out_bcd stays 12'h137, out_val stays 1, in_rdy stays 0 throughout; single transfer when out_rdy rises.
- Reset mid-operation: in = 200, rst high in cycle 4 → next cycle in_rdy = 1, out_val = 0, out_bcd = 0; a subsequent in = 42 → 12'h042 nine cycles later.
- Stream (8/3) of 99, 100, 7 with in_val and out_rdy held high → results 12'h099, 12'h100, 12'h007 in order, spaced 10 cycles apart (9 with `BIN_TO_BCD_ITER_OVERLAP_EN`).
- X-isolation: in = X while in_val = 0 for 3 cycles, then in = 58 with in_val = 1 → 12'h058 with no X on out_bcd.
